// File: rtl/inv_key_sched_pkg.sv
// rtl/inv_key_sched_pkg.sv - shared constants, state type and word helpers for inv_key_sched
package inv_key_sched_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_e;

    // Round constant top byte; the lower 24 bits of Rcon are always zero.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// rtl/inv_key_step.sv - one forward or inverse AES-128 key-expansion step on a shared SubWord path
module inv_key_step
    import inv_key_sched_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [7:0]       rcon_i,
    input  logic             inv_i,
    output logic [KEY_W-1:0] key_o
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] p1, p2, p3;
    logic [WORD_W-1:0] sb_in, sub, t;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    // Inverse direction recovers the previous w3 (= p3) first, then reuses the forward S-box on it.
    assign sb_in = rot_word(inv_i ? p3 : w3);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        s_box u_s_box (
            .in_i  (sb_in[8*i +: 8]),
            .out_o (sub[8*i +: 8])
        );
    end

    assign t = sub ^ {rcon_i, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_o = inv_i ? {w0 ^ t, p1, p2, p3} : {n0, n1, n2, n3};

endmodule

// File: rtl/s_box.sv
// rtl/s_box.sv - AES forward S-box, one byte in, one byte out
module s_box (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[{in_i, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_sched.sv
// rtl/inv_key_sched.sv - AES-128 decryption key schedule emitting round keys 10..0; INV_KEY_CACHE_EN adds a round-key cache
module inv_key_sched
    import inv_key_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] cipher_key,
    input  logic         key_ready,
    output logic [0:127] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [3:0]         ctr_q, ctr_d;
    logic [3:0]         rnum_q, rnum_d;
    logic               done_q, done_d;

    logic               step_inv;
    logic [7:0]         step_rcon;
    logic [KEY_W-1:0]   step_key;

`ifdef INV_KEY_CACHE_EN
    logic [KEY_W-1:0]   cache_q [0:NR];
    logic               cache_vld_q;
    logic               cache_hit;

    assign cache_hit = cache_vld_q && (cipher_key == cache_q[0]);
    assign step_inv  = 1'b0;
    assign step_rcon = rcon(ctr_q);

    // Entry 0 holds the cipher key; entries 1..10 fill in as the forward expansion runs.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start && !cache_hit) begin
            cache_q[0] <= cipher_key;
        end else if (state_q == EXPAND) begin
            cache_q[ctr_q] <= step_key;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_vld_q <= 1'b0;
        end else if (state_q == IDLE && start && !cache_hit) begin
            cache_vld_q <= 1'b0;
        end else if (state_q == EXPAND && ctr_q == LAST_ROUND) begin
            cache_vld_q <= 1'b1;
        end
    end

    assign round_key = (state_q == EMIT) ? cache_q[rnum_q] : '0;
`else
    assign step_inv  = (state_q == EMIT);
    assign step_rcon = rcon(step_inv ? rnum_q : ctr_q);
    assign round_key = (state_q == EMIT) ? key_q : '0;
`endif

    inv_key_step u_inv_key_step (
        .key_i  (key_q),
        .rcon_i (step_rcon),
        .inv_i  (step_inv),
        .key_o  (step_key)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ctr_d   = ctr_q;
        rnum_d  = rnum_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef INV_KEY_CACHE_EN
                    if (cache_hit) begin
                        state_d = EMIT;
                        rnum_d  = LAST_ROUND;
                    end else begin
`else
                    begin
`endif
                        key_d   = cipher_key;
                        ctr_d   = 4'd1;
                        state_d = EXPAND;
                    end
                end
            end
            EXPAND: begin
                key_d = step_key;
                ctr_d = ctr_q + 4'd1;
                if (ctr_q == LAST_ROUND) begin
                    ctr_d   = 4'd0;
                    rnum_d  = LAST_ROUND;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (rnum_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
`ifndef INV_KEY_CACHE_EN
                        key_d  = step_key;
`endif
                        rnum_d = rnum_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            ctr_q   <= '0;
            rnum_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ctr_q   <= ctr_d;
            rnum_q  <= rnum_d;
            done_q  <= done_d;
        end
    end

    assign round_num = rnum_q;
    assign key_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// tb/tb_inv_key_sched.sv - randomized self-checking bench for inv_key_sched against a word-level FIPS-197 expansion model
module tb_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [0:127] cipher_key;
    logic         key_ready;
    logic [0:127] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] model_rk [0:10];
    logic [127:0] got_key [0:10];
    logic [3:0]   got_num [0:10];
    int           lat, n_got, stall_bad;
    logic         end_done, end_valid, end_busy;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    inv_key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one start..done sequence, recording accepted keys; stalled cycles must keep outputs frozen.
    task automatic collect(input logic [127:0] key, input int ready_pct, input bit noise);
        logic [127:0] hold_key;
        logic [3:0]   hold_num;
        int           guard;
        cipher_key = key;
        start      = 1'b1;
        key_ready  = 1'b0;
        step();
        start = 1'b0;
        lat   = 1;
        while (!key_valid && lat < 40) begin
            start = noise && ($urandom_range(0, 2) == 0);
            if (start) cipher_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            lat++;
        end
        start = 1'b0;
        n_got = 0; stall_bad = 0; guard = 0;
        while (key_valid && n_got < 11 && guard < 400) begin
            key_ready = ($urandom_range(0, 99) < ready_pct);
            start     = noise && ($urandom_range(0, 3) == 0);
            if (start) cipher_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            hold_key = round_key;
            hold_num = round_num;
            if (key_ready) begin
                got_key[n_got] = round_key;
                got_num[n_got] = round_num;
                n_got++;
            end
            step();
            guard++;
            if (!key_ready && (round_key !== hold_key || round_num !== hold_num || key_valid !== 1'b1))
                stall_bad++;
        end
        start     = 1'b0;
        key_ready = 1'b0;
        end_done  = done;
        end_valid = key_valid;
        end_busy  = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
        step(); step();
        checks++; if (round_key !== 128'h0) begin errors++; $display("FAIL reset_round_key got %h expected 0", round_key); end
        checks++; if (round_num !== 4'd0) begin errors++; $display("FAIL reset_round_num got %0d expected 0", round_num); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b expected 0", key_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fips_vector;
        model_expand(FIPS_KEY);
        collect(FIPS_KEY, 100, 1'b0);
        checks++; if (lat !== 11) begin errors++; $display("FAIL fips_latency got %0d expected 11", lat); end
        checks++; if (n_got !== 11) begin errors++; $display("FAIL fips_count got %0d expected 11", n_got); end
        checks++; if (got_key[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("FAIL fips_round10 got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", got_key[0]); end
        checks++; if (got_num[0] !== 4'd10) begin errors++; $display("FAIL fips_num10 got %0d expected 10", got_num[0]); end
        checks++; if (got_key[1] !== 128'hac7766f319fadc2128d12941575c006e) begin errors++; $display("FAIL fips_round9 got %h expected ac7766f319fadc2128d12941575c006e", got_key[1]); end
        checks++; if (got_key[10] !== FIPS_KEY) begin errors++; $display("FAIL fips_round0 got %h expected %h", got_key[10], FIPS_KEY); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (got_key[i] !== model_rk[10-i]) begin errors++; $display("FAIL fips_key[%0d] got %h expected %h", 10-i, got_key[i], model_rk[10-i]); end
        end
        checks++; if (end_done !== 1'b1) begin errors++; $display("FAIL fips_done got %b expected 1", end_done); end
        checks++; if (end_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_end got %b expected 0", end_valid); end
        checks++; if (end_busy !== 1'b0) begin errors++; $display("FAIL fips_busy_end got %b expected 0", end_busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fips_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_stall;
        logic [127:0] key;
        for (int it = 0; it < 3; it++) begin
            key = (it == 0) ? FIPS_KEY : {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(key);
            collect(key, 45, 1'b0);
            checks++; if (n_got !== 11) begin errors++; $display("FAIL stall_count[%0d] got %0d expected 11", it, n_got); end
            checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold[%0d] got %0d changes expected 0", it, stall_bad); end
            for (int i = 0; i < 11; i++) begin
                checks++; if (got_key[i] !== model_rk[10-i] || got_num[i] !== 4'(10-i)) begin
                    errors++; $display("FAIL stall_key[%0d] got %h/%0d expected %h/%0d", it, got_key[i], got_num[i], model_rk[10-i], 10-i);
                end
            end
            checks++; if (end_done !== 1'b1) begin errors++; $display("FAIL stall_done[%0d] got %b expected 1", it, end_done); end
            step();
        end
    endtask

    task automatic test_start_ignored;
        logic [127:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        collect(key, 60, 1'b1);
        checks++; if (lat !== 11) begin errors++; $display("FAIL ignore_latency got %0d expected 11", lat); end
        checks++; if (n_got !== 11) begin errors++; $display("FAIL ignore_count got %0d expected 11", n_got); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (got_key[i] !== model_rk[10-i] || got_num[i] !== 4'(10-i)) begin
                errors++; $display("FAIL ignore_key[%0d] got %h/%0d expected %h", 10-i, got_key[i], got_num[i], model_rk[10-i]);
            end
        end
        checks++; if (end_done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b expected 1", end_done); end
        step();
    endtask

    task automatic test_reset_mid;
        logic [127:0] key;
        int guard;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        cipher_key = key; start = 1'b1; step(); start = 1'b0;
        key_ready = 1'b1; guard = 0;
        while (!(key_valid && round_num == 4'd5) && guard < 40) begin step(); guard++; end
        checks++; if (round_num !== 4'd5 || round_key !== model_rk[5]) begin errors++; $display("FAIL rstmid_round5 got %h/%0d expected %h/5", round_key, round_num, model_rk[5]); end
        rst_n = 1'b0;
        step();
        key_ready = 1'b0;
        checks++; if (round_key !== 128'h0 || round_num !== 4'd0) begin errors++; $display("FAIL rstmid_outputs got %h/%0d expected 0/0", round_key, round_num); end
        checks++; if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags got v%b b%b d%b expected 000", key_valid, busy, done); end
        rst_n = 1'b1;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after got d%b b%b expected 00", done, busy); end
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        collect(key, 70, 1'b0);
        checks++; if (lat !== 11 || n_got !== 11) begin errors++; $display("FAIL rstmid_rerun got lat %0d count %0d expected 11/11", lat, n_got); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (got_key[i] !== model_rk[10-i]) begin errors++; $display("FAIL rstmid_key[%0d] got %h expected %h", 10-i, got_key[i], model_rk[10-i]); end
        end
        step();
    endtask

    task automatic test_back_to_back;
        logic [127:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        collect(key, 100, 1'b0);
        checks++; if (end_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b expected 1", end_done); end
        model_expand(SEQ_KEY);
        collect(SEQ_KEY, 100, 1'b0);
        checks++; if (lat !== 11) begin errors++; $display("FAIL b2b_latency got %0d expected 11", lat); end
        checks++; if (got_key[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL b2b_round10 got %h expected 13111d7fe3944a17f307a78b4d2b30c5", got_key[0]); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (got_key[i] !== model_rk[10-i] || got_num[i] !== 4'(10-i)) begin
                errors++; $display("FAIL b2b_key[%0d] got %h/%0d expected %h", 10-i, got_key[i], got_num[i], model_rk[10-i]);
            end
        end
        step();
    endtask

`ifdef INV_KEY_CACHE_EN
    task automatic test_cache;
        logic [127:0] key;
        model_expand(SEQ_KEY);
        collect(SEQ_KEY, 100, 1'b0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL cache_hit_latency got %0d expected 1", lat); end
        for (int i = 0; i < 11; i++) begin
            checks++; if (got_key[i] !== model_rk[10-i]) begin errors++; $display("FAIL cache_key[%0d] got %h expected %h", 10-i, got_key[i], model_rk[10-i]); end
        end
        step();
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        collect(key, 100, 1'b0);
        checks++; if (lat !== 11) begin errors++; $display("FAIL cache_miss_latency got %0d expected 11", lat); end
        checks++; if (got_key[0] !== model_rk[10]) begin errors++; $display("FAIL cache_miss_round10 got %h expected %h", got_key[0], model_rk[10]); end
        step();
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; key_ready = 1'b0; cipher_key = '0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef INV_KEY_CACHE_EN
        test_cache();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
